// File: rtl/cci_pkg.sv
// Shared state encoding, widths and register map constants for the CCI target.
package cci_pkg;

    localparam int unsigned PTR_W  = 16;
    localparam int unsigned DATA_W = 8;

    localparam logic [PTR_W-1:0] MODEL_ID_HI = 16'h0000;
    localparam logic [PTR_W-1:0] MODEL_ID_LO = 16'h0001;
    localparam logic [PTR_W-1:0] MODE_SELECT = 16'h0100;

    typedef enum logic [3:0] {
        IDLE,
        DEV_ADDR,
        DEV_ACK,
        REG_HI,
        REG_HI_ACK,
        REG_LO,
        REG_LO_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        IGNORE
    } cci_state_t;

    // Where an ACK slot hands over to once the initiator has clocked it out.
    function automatic cci_state_t ack_next(input cci_state_t s);
        cci_state_t n;
        case (s)
            DEV_ACK:    n = REG_HI;
            REG_HI_ACK: n = REG_LO;
            default:    n = WR_DATA;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/cci_if.sv
// Register-side outputs of the CCI target: mode bit, write reporting and busy.
interface cci_if;
    import cci_pkg::*;

    logic              streaming;
    logic              wr_strobe;
    logic [PTR_W-1:0]  wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;

    modport master (output streaming, wr_strobe, wr_addr, wr_data, busy);
    modport slave  (input  streaming, wr_strobe, wr_addr, wr_data, busy);

endinterface

// File: rtl/cci_bus_sync.sv
// Brings scl/sda into the clk_in domain and flags scl edges plus START/STOP.
module cci_bus_sync (
    input  logic clk_in,
    input  logic reset,
    input  logic scl,
    input  logic sda,
    output logic sda_s,
    output logic scl_rise_c,
    output logic scl_fall_c,
    output logic start_c,
    output logic stop_c
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_q;
    logic       sda_q;

    // Synchronizers reset to the idle-bus level so reset release creates no event.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda};
            scl_q    <= scl_sync[1];
            sda_q    <= sda_sync[1];
        end
    end

    assign sda_s      = sda_sync[1];
    assign scl_rise_c = scl_sync[1] & ~scl_q;
    assign scl_fall_c = ~scl_sync[1] & scl_q;
    assign start_c    = scl_sync[1] & scl_q & sda_q & ~sda_sync[1];
    assign stop_c     = scl_sync[1] & scl_q & ~sda_q & sda_sync[1];

endmodule

// File: rtl/cci_target.sv
// CCI register target: device-address match, 16-bit auto-incrementing pointer,
// byte register file with read-only model ID and a per-byte write strobe.
module cci_target
    import cci_pkg::*;
#(
    parameter logic [6:0]  DEVICE_ADDRESS = 7'h10,
    parameter logic [15:0] MODEL_ID       = 16'h0219,
    parameter int unsigned REG_DEPTH      = 512
) (
    input  logic  clk_in,
    input  logic  reset,
    input  logic  scl,
    inout  wire   sda,
    cci_if.master reg_bus
);

    localparam int unsigned AW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

    cci_state_t        state;
    logic [PTR_W-1:0]  ptr;
    logic [DATA_W-1:0] shift;
    logic [2:0]        bit_cnt;
    logic              byte_done;
    logic              ack_drive;
    logic              rw;
    logic              master_ack;
    logic              sda_oe;
    logic [DATA_W-1:0] regs [REG_DEPTH];

    logic              sda_s;
    logic              scl_rise_c;
    logic              scl_fall_c;
    logic              start_c;
    logic              stop_c;
    logic [DATA_W-1:0] byte_in_c;
    logic [DATA_W-1:0] rd_cur_c;
    logic [DATA_W-1:0] rd_nxt_c;
    logic [PTR_W-1:0]  ptr_inc_c;
    logic              wr_ok_c;

    cci_bus_sync u_sync (
        .clk_in     (clk_in),
        .reset      (reset),
        .scl        (scl),
        .sda        (sda),
        .sda_s      (sda_s),
        .scl_rise_c (scl_rise_c),
        .scl_fall_c (scl_fall_c),
        .start_c    (start_c),
        .stop_c     (stop_c)
    );

    // Open drain: only ever pull low.
    assign sda = sda_oe ? 1'b0 : 1'bz;

    function automatic logic in_range(input logic [PTR_W-1:0] a);
        return 32'(a) < REG_DEPTH;
    endfunction

    function automatic logic [DATA_W-1:0] reg_read(input logic [PTR_W-1:0] a);
        logic [DATA_W-1:0] v;
        if (a == MODEL_ID_HI)      v = MODEL_ID[15:8];
        else if (a == MODEL_ID_LO) v = MODEL_ID[7:0];
        else if (in_range(a))      v = regs[a[AW-1:0]];
        else                       v = '0;
        return v;
    endfunction

    always_comb begin
        byte_in_c = {shift[DATA_W-2:0], sda_s};
        ptr_inc_c = ptr + PTR_W'(1);
        rd_cur_c  = reg_read(ptr);
        rd_nxt_c  = reg_read(ptr_inc_c);
        wr_ok_c   = (ptr != MODEL_ID_HI) && (ptr != MODEL_ID_LO) && in_range(ptr);
    end

    // Protocol FSM and register file; bits sampled on scl rise, sda moved on scl fall.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            ptr               <= '0;
            shift             <= '0;
            bit_cnt           <= '0;
            byte_done         <= 1'b0;
            ack_drive         <= 1'b0;
            rw                <= 1'b0;
            master_ack        <= 1'b0;
            sda_oe            <= 1'b0;
            reg_bus.streaming <= 1'b0;
            reg_bus.wr_strobe <= 1'b0;
            reg_bus.wr_addr   <= '0;
            reg_bus.wr_data   <= '0;
            reg_bus.busy      <= 1'b0;
            for (int unsigned i = 0; i < REG_DEPTH; i++) regs[AW'(i)] <= '0;
        end else begin
            reg_bus.wr_strobe <= 1'b0;
            if (stop_c) begin
                state        <= IDLE;
                sda_oe       <= 1'b0;
                ack_drive    <= 1'b0;
                reg_bus.busy <= 1'b0;
            end else if (start_c) begin
                state     <= DEV_ADDR;
                sda_oe    <= 1'b0;
                ack_drive <= 1'b0;
                bit_cnt   <= '0;
            end else begin
                case (state)
                    DEV_ADDR: if (scl_rise_c) begin
                        shift   <= byte_in_c;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (byte_in_c[7:1] == DEVICE_ADDRESS) begin
                                state        <= DEV_ACK;
                                rw           <= byte_in_c[0];
                                reg_bus.busy <= 1'b1;
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end
                    REG_HI, REG_LO: if (scl_rise_c) begin
                        shift   <= byte_in_c;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (state == REG_HI) begin
                                ptr[15:8] <= byte_in_c;
                                state     <= REG_HI_ACK;
                            end else begin
                                ptr[7:0] <= byte_in_c;
                                state    <= REG_LO_ACK;
                            end
                        end
                    end
                    WR_DATA: if (scl_rise_c) begin
                        shift   <= byte_in_c;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            reg_bus.wr_strobe <= 1'b1;
                            reg_bus.wr_addr   <= ptr;
                            reg_bus.wr_data   <= byte_in_c;
                            if (wr_ok_c) begin
                                regs[ptr[AW-1:0]] <= byte_in_c;
                                if (ptr == MODE_SELECT) reg_bus.streaming <= byte_in_c[0];
                            end
                            ptr   <= ptr_inc_c;
                            state <= WR_ACK;
                        end
                    end
                    // First fall after the 8th bit asserts ACK, the 9th fall ends it.
                    DEV_ACK, REG_HI_ACK, REG_LO_ACK, WR_ACK: if (scl_fall_c) begin
                        if (!ack_drive) begin
                            ack_drive <= 1'b1;
                            sda_oe    <= 1'b1;
                        end else begin
                            ack_drive <= 1'b0;
                            bit_cnt   <= '0;
                            if (state == DEV_ACK && rw) begin
                                state     <= RD_DATA;
                                shift     <= rd_cur_c;
                                sda_oe    <= ~rd_cur_c[7];
                                byte_done <= 1'b0;
                            end else begin
                                state  <= ack_next(state);
                                sda_oe <= 1'b0;
                            end
                        end
                    end
                    RD_DATA: begin
                        if (scl_rise_c) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) byte_done <= 1'b1;
                        end else if (scl_fall_c) begin
                            if (byte_done) begin
                                byte_done <= 1'b0;
                                sda_oe    <= 1'b0;
                                state     <= RD_ACK;
                            end else begin
                                shift  <= {shift[DATA_W-2:0], 1'b0};
                                sda_oe <= ~shift[DATA_W-2];
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise_c) begin
                            master_ack <= ~sda_s;
                        end else if (scl_fall_c) begin
                            if (master_ack) begin
                                ptr     <= ptr_inc_c;
                                shift   <= rd_nxt_c;
                                sda_oe  <= ~rd_nxt_c[7];
                                bit_cnt <= '0;
                                state   <= RD_DATA;
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end
                    IDLE, IGNORE: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/cci_target.md
CCI_TARGET -- requirements
Module: cci_target

Interface
REQ-001 SHALL have parameter DEVICE_ADDRESS, default 7'h10; 7-bit I2C address the block responds to.
REQ-002 SHALL have parameter MODEL_ID, default 16'h0219; read-only value at registers 0x0000 (high byte) and 0x0001 (low byte).
REQ-003 SHALL have parameter REG_DEPTH, default 512; number of byte registers implemented at addresses 0x0000..REG_DEPTH-1.
REQ-004 clk_in  input  1  system clock; SHALL be at least 8x SCL frequency.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 scl  input  1  bus clock from the initiator, asynchronous to clk_in.
REQ-007 sda  inout  1  open-drain data; the block SHALL drive only 1'b0 or 1'bz.
REQ-008 streaming  output  1  bit 0 of register 0x0100 (mode_select).
REQ-009 wr_strobe  output  1  one-cycle pulse per accepted data-byte write.
REQ-010 wr_addr  output  16  register address of the write flagged by wr_strobe.
REQ-011 wr_data  output  8  data byte of the write flagged by wr_strobe.
REQ-012 busy  output  1  high from a START matching DEVICE_ADDRESS until the next STOP.

Function
REQ-013 scl and sda SHALL each pass through a 2-flop synchronizer; edge detection SHALL use only synchronized values.
REQ-014 START = sda falling while scl high; STOP = sda rising while scl high; both SHALL be recognized in every state.
REQ-015 Bits SHALL be sampled on synchronized scl rising edges, MSB first; sda SHALL change only after synchronized scl falling edges.
REQ-016 States: IDLE, DEV_ADDR, DEV_ACK, REG_HI, REG_HI_ACK, REG_LO, REG_LO_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
REQ-017 START from any state SHALL enter DEV_ADDR; STOP from any state SHALL enter IDLE and release sda.
REQ-018 DEV_ADDR: after 8 bits, address match -> DEV_ACK; mismatch -> IGNORE with sda released (NACK).
REQ-019 DEV_ACK: drive sda low for the 9th clock; R/W=0 -> REG_HI; R/W=1 -> RD_DATA.
REQ-020 REG_HI/REG_LO SHALL load the 16-bit register pointer high then low byte, each ACKed; REG_LO_ACK -> WR_DATA.
REQ-021 WR_DATA: each byte SHALL be ACKed, written to the pointer address, pulse wr_strobe once, and increment the pointer.
REQ-022 Writes to 0x0000/0x0001 or addresses >= REG_DEPTH SHALL be ACKed, pulse wr_strobe, and not change any register.
REQ-023 RD_DATA SHALL shift out the byte at the pointer; 0x0000/0x0001 return MODEL_ID bytes; addresses >= REG_DEPTH return 8'h00.
REQ-024 RD_ACK: sda released; initiator ACK (low) -> increment pointer, RD_DATA; NACK (high) -> IGNORE.
REQ-025 Repeated START SHALL preserve the register pointer (write-pointer-then-read sequence).
REQ-026 Pointer SHALL wrap 16'hFFFF -> 16'h0000.
REQ-027 No clock stretching; scl SHALL never be driven.

Reset
REQ-028 Reset SHALL force state IDLE, sda released, pointer 16'h0000, all registers 8'h00, streaming 0, wr_strobe 0, wr_addr 16'h0000, wr_data 8'h00, busy 0.
REQ-029 Reset asserted mid-transfer SHALL release sda within one clk_in cycle; block resumes only on a fresh START.

Structure
REQ-030 State enum and register address constants (MODEL_ID_HI 16'h0000, MODEL_ID_LO 16'h0001, MODE_SELECT 16'h0100) SHALL live in shared package cci_pkg.
REQ-031 Synchronizer and START/STOP/edge detection SHALL be sub-module cci_bus_sync; FSM and register file stay in cci_target.

Verification
REQ-032 Write 0x10/W, 0x01,0x00, 0x01, STOP -> all four bytes ACKed, streaming=1, one wr_strobe with wr_addr=0x0100, wr_data=0x01.
REQ-033 Write 0x10/W, 0x00,0x00; repeated START 0x10/R, read 2 bytes ACK then NACK -> data 0x02, 0x19.
REQ-034 Address 0x36/W -> NACK on 9th bit, sda never driven low until next START, busy=0.
REQ-035 Write pointer 0xFFFF, data 0xAA,0x55 -> two wr_strobe pulses with wr_addr 0xFFFF then 0x0000; read 0x0000 still returns 0x02.
REQ-036 Assert reset during DEV_ACK with sda low -> sda released within 1 clk_in; next transaction to 0x10 ACKed normally.
REQ-037 STOP after only 4 data bits of WR_DATA -> no wr_strobe, register unchanged, state IDLE.
